// File: rtl/mulred_arb_k_if.sv
// Requester / result bundle for the shared Kyber multiply-reduce arbiter.
// stall_cnt_o exists only when MULRED_ARB_K_STAT_EN is defined.
interface mulred_arb_k_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid_i;
    logic [12*N_REQ-1:0] req_a_i;
    logic [12*N_REQ-1:0] req_b_i;
    logic [N_REQ-1:0]    req_ready_o;
    logic                res_valid_o;
    logic                res_ready_i;
    logic [11:0]         res_data_o;
    logic [ID_W-1:0]     res_id_o;
`ifdef MULRED_ARB_K_STAT_EN
    logic [15:0]         stall_cnt_o;
`endif

    modport master (
        output req_valid_i, req_a_i, req_b_i, res_ready_i,
        input  req_ready_o, res_valid_o, res_data_o, res_id_o
`ifdef MULRED_ARB_K_STAT_EN
        , input stall_cnt_o
`endif
    );

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, res_ready_i,
        output req_ready_o, res_valid_o, res_data_o, res_id_o
`ifdef MULRED_ARB_K_STAT_EN
        , output stall_cnt_o
`endif
    );
endinterface

// File: rtl/mulred_arb_k.sv
// Round-robin arbiter feeding one 12x12 multiplier + Barrett reduction (q=3329), 2-stage pipe.
// Define MULRED_ARB_K_STAT_EN to add the saturating output-stall counter stall_cnt_o.
module mulred_arb_k #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    mulred_arb_k_if.slave  bus
);
    localparam logic [14:0] BAR_M = 15'd20158;   // floor(2^26 / 3329)
    localparam logic [24:0] Q25   = 25'd3329;

    logic              s1_v_q, s1_v_d;
    logic [23:0]       s1_p_q, s1_p_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    logic              res_valid_q, res_valid_d;
    logic [11:0]       res_data_q, res_data_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;

    logic              adv1, adv2, accept, win_found;
    logic [N_REQ-1:0]  valid_rot, grant;
    logic [ID_W-1:0]   win_off, win_idx;
    logic [ID_W:0]     win_sum;
    logic [11:0]       win_a, win_b;
    logic [11:0]       op_a [N_REQ];
    logic [11:0]       op_b [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign op_a[gi] = bus.req_a_i[12*gi +: 12];
            assign op_b[gi] = bus.req_b_i[12*gi +: 12];
        end
    endgenerate

    assign adv2 = !res_valid_q || bus.res_ready_i;
    assign adv1 = !s1_v_q || adv2;

    // Rotate valids so bit 0 is the requester at ptr; the lowest set bit is the winner.
    always_comb begin
        valid_rot = N_REQ'({bus.req_valid_i, bus.req_valid_i} >> ptr_q);
        win_found = 1'b0;
        win_off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (valid_rot[i]) begin
                win_found = 1'b1;
                win_off   = ID_W'(i);
            end
        end
        win_sum = {1'b0, ptr_q} + {1'b0, win_off};
        if (win_sum >= (ID_W+1)'(N_REQ)) begin
            win_sum = win_sum - (ID_W+1)'(N_REQ);
        end
        win_idx = ID_W'(win_sum);
    end

    // Reset is folded in so no grant is visible while rst_n_i is low.
    assign grant  = (adv1 && win_found && rst_n_i) ? (N_REQ'(1) << win_idx) : '0;
    assign accept = |(grant & bus.req_valid_i);
    assign win_a  = op_a[win_idx];
    assign win_b  = op_b[win_idx];

    // Barrett: t never exceeds floor(p/q), and r stays below 3q, so two trims suffice.
    logic [38:0] bar_prod;
    logic [12:0] bar_t;
    logic [24:0] bar_tq, bar_r, bar_r1, bar_r2;
    always_comb begin
        bar_prod = {15'd0, s1_p_q} * {24'd0, BAR_M};
        bar_t    = 13'(bar_prod >> 26);
        bar_tq   = {12'd0, bar_t} * Q25;
        bar_r    = {1'b0, s1_p_q} - bar_tq;
        bar_r1   = (bar_r  >= Q25) ? bar_r  - Q25 : bar_r;
        bar_r2   = (bar_r1 >= Q25) ? bar_r1 - Q25 : bar_r1;
    end

    always_comb begin
        s1_v_d      = s1_v_q;
        s1_p_d      = s1_p_q;
        s1_id_d     = s1_id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        ptr_d       = ptr_q;
        if (adv2) begin
            res_valid_d = s1_v_q;
            res_data_d  = 12'(bar_r2);
            res_id_d    = s1_id_q;
        end
        if (adv1) begin
            s1_v_d = accept;
        end
        if (accept) begin
            s1_p_d  = {12'd0, win_a} * {12'd0, win_b};
            s1_id_d = win_idx;
            ptr_d   = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_v_q      <= 1'b0;
            s1_p_q      <= '0;
            s1_id_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_p_q      <= s1_p_d;
            s1_id_q     <= s1_id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef MULRED_ARB_K_STAT_EN
    logic [15:0] stall_q, stall_d;
    always_comb begin
        stall_d = stall_q;
        if (res_valid_q && !bus.res_ready_i && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) stall_q <= '0;
        else          stall_q <= stall_d;
    end
    assign bus.stall_cnt_o = stall_q;
`endif

    assign bus.req_ready_o = grant;
    assign bus.res_valid_o = res_valid_q;
    assign bus.res_data_o  = res_data_q;
    assign bus.res_id_o    = res_id_q;
endmodule

// File: tb/tb_mulred_arb_k.sv
// Self-checking bench for mulred_arb_k: cycle model of the arbiter/pipe plus an ordered result scoreboard.
// Honours MULRED_ARB_K_STAT_EN for the stall counter checks.
module tb_mulred_arb_k;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int Q   = 3329;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mulred_arb_k_if #(.N_REQ(N), .ID_W(IDW)) bus ();
    mulred_arb_k #(.N_REQ(N), .ID_W(IDW)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Requester sources: pending operand pairs per requester
    logic [11:0] src_a [N][$];
    logic [11:0] src_b [N][$];
    logic [N-1:0] acc_seen = '0;
    bit rand_mode = 1'b0;

    // Model state
    bit          m_ov, m_mv;
    logic [11:0] m_od, m_md;
    int          m_oid, m_mid, m_ptr, m_stall;
    typedef struct { int id; int data; } txn_t;
    txn_t sb[$];

    // Logs for directed literal checks
    int cyc = 0;
    int res_log_id[$], res_log_data[$], res_log_cyc[$];
    int acc_log[$], acc_log_cyc[$];
    int exp_d4[4] = '{6, 13, 2671, 0};

    always @(posedge clk) cyc <= cyc + 1;

    // Source driver: hold valid+operands until accepted
    initial begin
        bus.req_valid_i = '0;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc_seen[k] && src_a[k].size() > 0) begin
                    void'(src_a[k].pop_front());
                    void'(src_b[k].pop_front());
                end else if (bus.req_valid_i[k] && src_a[k].size() > 0) begin
                    continue;
                end
                bus.req_valid_i[k] = (src_a[k].size() > 0) && (!rand_mode || $urandom_range(0, 2) != 0);
                if (src_a[k].size() > 0) begin
                    bus.req_a_i[12*k +: 12] = src_a[k][0];
                    bus.req_b_i[12*k +: 12] = src_b[k][0];
                end
            end
        end
    end

    // Compare + model step, once per cycle on the falling edge
    always @(negedge clk) begin : cmp
        bit adv1, adv2, found;
        int win, kk;
        logic [N-1:0] exp_rdy;
        logic [11:0] ma, mb;
        txn_t t;
        acc_seen = bus.req_valid_i & bus.req_ready_o;
        if (!rst_n) begin
            check("rst_req_ready", bus.req_ready_o, 0);
            check("rst_res_valid", bus.res_valid_o, 0);
            m_ov = 0; m_mv = 0; m_od = 0; m_md = 0; m_oid = 0; m_mid = 0;
            m_ptr = 0; m_stall = 0;
            sb.delete();
        end else begin
            adv2 = !m_ov || bus.res_ready_i;
            adv1 = !m_mv || adv2;
            found = 0; win = 0;
            for (int i = 0; i < N; i++) begin
                kk = (m_ptr + i) % N;
                if (!found && bus.req_valid_i[kk]) begin found = 1; win = kk; end
            end
            exp_rdy = (adv1 && found) ? (N'(1) << win) : '0;
            check("req_ready", bus.req_ready_o, exp_rdy);
            check("res_valid", bus.res_valid_o, m_ov);
            if (m_ov) begin
                check("res_data", bus.res_data_o, m_od);
                check("res_id", bus.res_id_o, m_oid);
            end
`ifdef MULRED_ARB_K_STAT_EN
            check("stall_cnt", bus.stall_cnt_o, m_stall);
`endif
            if (bus.res_valid_o && bus.res_ready_i) begin
                $display("txn cyc=%0d id=%0d data=%0d", cyc, bus.res_id_o, bus.res_data_o);
                res_log_id.push_back(int'(bus.res_id_o));
                res_log_data.push_back(int'(bus.res_data_o));
                res_log_cyc.push_back(cyc);
                if (sb.size() > 0) begin
                    t = sb.pop_front();
                    check("sb_id", bus.res_id_o, t.id);
                    check("sb_data", bus.res_data_o, t.data);
                end else begin
                    check("sb_unexpected_result", bus.res_valid_o, 0);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (acc_seen[i]) begin acc_log.push_back(i); acc_log_cyc.push_back(cyc); end
            end
            if (m_ov && !bus.res_ready_i && m_stall < 65535) m_stall++;
            if (adv2) begin m_ov = m_mv; m_od = m_md; m_oid = m_mid; end
            if (adv1) begin
                m_mv = found;
                if (found) begin
                    ma = bus.req_a_i[12*win +: 12];
                    mb = bus.req_b_i[12*win +: 12];
                    m_md  = 12'((int'(ma) * int'(mb)) % Q);
                    m_mid = win;
                    m_ptr = (win + 1) % N;
                    sb.push_back('{win, int'(m_md)});
                end
            end
        end
    end

    task automatic clear_logs();
        res_log_id.delete(); res_log_data.delete(); res_log_cyc.delete();
        acc_log.delete(); acc_log_cyc.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic push(input int k, input int a, input int b);
        src_a[k].push_back(12'(a));
        src_b[k].push_back(12'(b));
    endtask

    task automatic drain(input int limit);
        bit done;
        bus.res_ready_i = 1'b1;
        done = 0;
        for (int i = 0; i < limit && !done; i++) begin
            @(posedge clk); #1;
            done = (bus.req_valid_i == '0) && !m_ov && !m_mv;
            for (int k = 0; k < N; k++) if (src_a[k].size() != 0) done = 0;
        end
        check("drain_done", {31'd0, done}, 1);
    endtask

    int snap;
    initial begin
        bus.res_ready_i = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_res_valid", bus.res_valid_o, 0);
        check("reset_res_data", bus.res_data_o, 0);
        check("reset_res_id", bus.res_id_o, 0);
        check("reset_req_ready", bus.req_ready_o, 0);
`ifdef MULRED_ARB_K_STAT_EN
        check("reset_stall_cnt", bus.stall_cnt_o, 0);
`endif
        rst_n = 1'b1;
        clear_logs();

        // Single request, max operands, latency 2 edges from acceptance
        push(0, 3328, 3328);
        drain(50);
        check("single_count", res_log_data.size(), 1);
        check("single_data", res_log_data[0], 1);
        check("single_id", res_log_id[0], 0);
        check("single_latency", res_log_cyc[0] - acc_log_cyc[0], 2);

        // Four simultaneous requests from ptr=0
        do_reset();
        push(0, 2, 3); push(1, 100, 100); push(2, 3000, 2); push(3, 1, 0);
        drain(50);
        for (int i = 0; i < 4; i++) begin
            check("four_grant", acc_log[i], i);
            check("four_data", res_log_data[i], exp_d4[i]);
            check("four_id", res_log_id[i], i);
        end
        check("four_back2back", acc_log_cyc[3] - acc_log_cyc[0], 3);

        // Fairness between requesters 0 and 2
        do_reset();
        for (int i = 0; i < 6; i++) begin push(0, i, 7); push(2, 3328 - i, 5); end
        drain(100);
        for (int i = 0; i < 8; i++) check("fair_grant", acc_log[i], (i % 2 == 0) ? 0 : 2);

        // Back-pressure from empty: exactly two accepted, then blocked
        do_reset();
        bus.res_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) push(1, 1000 + i, 3);
        repeat (5) @(posedge clk);
        #1;
        check("bp_accepts", acc_log.size(), 2);
        check("bp_ready_low", bus.req_ready_o, 0);
        check("bp_res_valid", bus.res_valid_o, 1);
        drain(100);
        check("bp_results", res_log_data.size(), 6);

`ifdef MULRED_ARB_K_STAT_EN
        // Full pipe stalled for five cycles
        for (int i = 0; i < 10; i++) push(1, 5 * i, 9);
        repeat (4) @(posedge clk);
        #1;
        snap = int'(bus.stall_cnt_o);
        bus.res_ready_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stall_delta", int'(bus.stall_cnt_o) - snap, 5);
        drain(100);
`endif

        // Reset with S1 and S2 full
        do_reset();
        bus.res_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin push(1, 11 + i, 13); push(3, 17 + i, 19); end
        repeat (4) @(posedge clk);
        #1;
        check("mid_full_valid", bus.res_valid_o, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.res_valid_o, 0);
        check("mid_rst_ready", bus.req_ready_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
        bus.res_ready_i = 1'b1;
        drain(100);
        check("mid_first_grant", acc_log[0], 1);
        check("mid_results", res_log_data.size(), 6);

        // Random regression
        do_reset();
        rand_mode = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #2;
            bus.res_ready_i = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                if (src_a[k].size() < 4 && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 7) == 0)
                        push(k, ($urandom_range(0, 1) != 0) ? 3328 : 0, 3328);
                    else
                        push(k, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1));
                end
            end
        end
        rand_mode = 1'b0;
        drain(2000);
        check("rand_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
